// File: rtl/biu_pkg.sv
// Shared types and helpers for the multi-region bus interface slave.
// Holds the FSM state encoding, debug error codes and byte-lane arithmetic.
package biu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } biu_state_t;

  // Kept with each response so the cause of an error stays visible when debugging.
  typedef enum logic [1:0] {
    ErrOk,
    ErrDecode,
    ErrAlign,
    ErrTimeout
  } biu_err_e;

  localparam int unsigned ByteWidth = 8;

  // Address bits that select a byte within one data word.
  function automatic int unsigned lane_shift(input int unsigned data_width);
    return $clog2(data_width / ByteWidth);
  endfunction

endpackage

// File: rtl/biu_addr_decode.sv
// Combinational window decoder: matches an address against every region, keeps the
// lowest-index hit, and reports the region-relative offset and word misalignment.
module biu_addr_decode
  import biu_pkg::*;
#(
  parameter int unsigned                        AddrWidth  = 32,
  parameter int unsigned                        DataWidth  = 32,
  parameter int unsigned                        NumRegions = 2,
  parameter logic [NumRegions*AddrWidth-1:0]    BaseAddrs  = '0,
  parameter logic [NumRegions*AddrWidth-1:0]    AddrSpans  = {NumRegions{AddrWidth'(4)}},
  parameter bit                                 Aligned    = 1'b1
) (
  input  logic [AddrWidth-1:0]  addr_i,
  output logic                  hit_o,
  output logic [NumRegions-1:0] sel_o,
  output logic [AddrWidth-1:0]  offset_o,
  output logic                  misalign_o
);

  localparam int unsigned LaneShift = lane_shift(DataWidth);
  localparam logic [AddrWidth-1:0] LaneMask = AddrWidth'((64'd1 << LaneShift) - 64'd1);

  logic [AddrWidth-1:0] diff;

  // Walk from the highest index down so the lowest overlapping region wins. The
  // subtraction wraps, so a window at the top of the map needs no special case.
  always_comb begin
    hit_o    = 1'b0;
    sel_o    = '0;
    offset_o = '0;
    diff     = '0;
    for (int r = NumRegions - 1; r >= 0; r--) begin
      diff = addr_i - BaseAddrs[r*AddrWidth +: AddrWidth];
      if (diff < AddrSpans[r*AddrWidth +: AddrWidth]) begin
        hit_o    = 1'b1;
        sel_o    = '0;
        sel_o[r] = 1'b1;
        offset_o = Aligned ? (diff >> LaneShift) : diff;
      end
    end
  end

  assign misalign_o = Aligned && ((addr_i & LaneMask) != '0);

endmodule

// File: rtl/biu_slave_mr.sv
// Multi-region bus interface slave: accepts one request at a time, forwards hits to
// the selected target and returns read data or an error response.
module biu_slave_mr
  import biu_pkg::*;
#(
  parameter int unsigned                        AddrWidth     = 32,
  parameter int unsigned                        DataWidth     = 32,
  parameter int unsigned                        NumRegions    = 2,
  parameter logic [NumRegions*AddrWidth-1:0]    BaseAddrs     = '0,
  parameter logic [NumRegions*AddrWidth-1:0]    AddrSpans     = {NumRegions{AddrWidth'(4)}},
  parameter bit                                 Aligned       = 1'b1,
  parameter int unsigned                        TimeoutCycles = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_rnw_i,
  input  logic [AddrWidth-1:0]            req_addr_i,
  input  logic [DataWidth-1:0]            req_wdata_i,
  input  logic [DataWidth/8-1:0]          req_be_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [DataWidth-1:0]            rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic [1:0]                      rsp_err_code_o,
  output logic [NumRegions-1:0]           tgt_req_o,
  output logic                            tgt_rnw_o,
  output logic [AddrWidth-1:0]            tgt_offset_o,
  output logic [DataWidth-1:0]            tgt_wdata_o,
  output logic [DataWidth/8-1:0]          tgt_be_o,
  input  logic [NumRegions-1:0]           tgt_ack_i,
  input  logic [NumRegions*DataWidth-1:0] tgt_rdata_i
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  biu_state_t             state_q;
  logic                   req_ready_q;
  logic                   rsp_valid_q;
  logic                   rsp_err_q;
  logic [DataWidth-1:0]   rsp_rdata_q;
  biu_err_e               err_code_q;
  logic [NumRegions-1:0]  tgt_req_q;
  logic                   tgt_rnw_q;
  logic [AddrWidth-1:0]   tgt_offset_q;
  logic [DataWidth-1:0]   tgt_wdata_q;
  logic [DataWidth/8-1:0] tgt_be_q;
  logic [CntW-1:0]        cnt_q;

  logic                   dec_hit;
  logic [NumRegions-1:0]  dec_sel;
  logic [AddrWidth-1:0]   dec_offset;
  logic                   dec_misalign;
  logic                   ack_hit;
  logic                   timeout_hit;
  logic [DataWidth-1:0]   rdata_sel;

  biu_addr_decode #(
    .AddrWidth  (AddrWidth),
    .DataWidth  (DataWidth),
    .NumRegions (NumRegions),
    .BaseAddrs  (BaseAddrs),
    .AddrSpans  (AddrSpans),
    .Aligned    (Aligned)
  ) u_decode (
    .addr_i     (req_addr_i),
    .hit_o      (dec_hit),
    .sel_o      (dec_sel),
    .offset_o   (dec_offset),
    .misalign_o (dec_misalign)
  );

  // Only the ack of the region currently requested counts; tgt_req_q is zero
  // outside the wait state, so stray acks there are dropped as well.
  assign ack_hit     = |(tgt_ack_i & tgt_req_q);
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);

  always_comb begin
    rdata_sel = '0;
    for (int r = 0; r < NumRegions; r++) begin
      if (tgt_req_q[r]) begin
        rdata_sel |= tgt_rdata_i[r*DataWidth +: DataWidth];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      err_code_q   <= ErrOk;
      tgt_req_q    <= '0;
      tgt_rnw_q    <= 1'b0;
      tgt_offset_q <= '0;
      tgt_wdata_q  <= '0;
      tgt_be_q     <= '0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            req_ready_q  <= 1'b0;
            tgt_rnw_q    <= req_rnw_i;
            tgt_wdata_q  <= req_wdata_i;
            tgt_be_q     <= req_be_i;
            tgt_offset_q <= dec_offset;
            cnt_q        <= '0;
            if (!dec_hit || dec_misalign) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
              err_code_q  <= !dec_hit ? ErrDecode : ErrAlign;
              state_q     <= StResp;
            end else begin
              tgt_req_q <= dec_sel;
              state_q   <= StWait;
            end
          end
        end
        StWait: begin
          // An ack arriving in the timeout cycle still completes normally.
          if (ack_hit) begin
            tgt_req_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= tgt_rnw_q ? rdata_sel : '0;
            err_code_q  <= ErrOk;
            state_q     <= StResp;
          end else if (timeout_hit) begin
            tgt_req_q   <= '0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            err_code_q  <= ErrTimeout;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o    = req_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign rsp_err_code_o = err_code_q;
  assign tgt_req_o      = tgt_req_q;
  assign tgt_rnw_o      = tgt_rnw_q;
  assign tgt_offset_o   = tgt_offset_q;
  assign tgt_wdata_o    = tgt_wdata_q;
  assign tgt_be_o       = tgt_be_q;

endmodule

// File: tb/tb_biu_slave_mr.sv
// Directed bench for biu_slave_mr: two regions, word-aligned, 16-cycle timeout.
module tb_biu_slave_mr;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rnw;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_err_code;
  logic [1:0]  tgt_req;
  logic        tgt_rnw;
  logic [31:0] tgt_offset;
  logic [31:0] tgt_wdata;
  logic [3:0]  tgt_be;
  logic [1:0]  tgt_ack;
  logic [63:0] tgt_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  biu_slave_mr #(
    .AddrWidth     (32),
    .DataWidth     (32),
    .NumRegions    (2),
    .BaseAddrs     ({32'h8000_1000, 32'h8000_0000}),
    .AddrSpans     ({32'h0000_0010, 32'h0000_0004}),
    .Aligned       (1'b1),
    .TimeoutCycles (16)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_rnw_i      (req_rnw),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_be_i       (req_be),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .rsp_err_code_o (rsp_err_code),
    .tgt_req_o      (tgt_req),
    .tgt_rnw_o      (tgt_rnw),
    .tgt_offset_o   (tgt_offset),
    .tgt_wdata_o    (tgt_wdata),
    .tgt_be_o       (tgt_be),
    .tgt_ack_i      (tgt_ack),
    .tgt_rdata_i    (tgt_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single cycle; returns 1 time unit after the accept edge.
  task automatic drive_req(input logic rnw, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
    req_rnw   = rnw;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++; if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    n_checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: got valid=%b err=%b want 0 0", rsp_valid, rsp_err); end
    n_checks++; if (rsp_rdata !== 32'h0 || tgt_req !== 2'b00) begin
      n_fail++; $display("FAIL reset_data_req: got rdata=%h req=%b want 0 00", rsp_rdata, tgt_req);
    end
    n_checks++; if ({tgt_rnw, tgt_offset, tgt_wdata, tgt_be} !== 69'h0) begin
      n_fail++; $display("FAIL reset_tgt_latches: got rnw=%b off=%h wd=%h be=%b want all 0",
                         tgt_rnw, tgt_offset, tgt_wdata, tgt_be);
    end
  endtask

  task automatic test_read_hit();
    drive_req(1'b1, 32'h8000_0000, 32'h0, 4'hF);
    n_checks++; if (tgt_req !== 2'b01 || tgt_offset !== 32'h0 || tgt_rnw !== 1'b1) begin
      n_fail++; $display("FAIL rd_tgt: got req=%b off=%h rnw=%b want 01 0 1",
                         tgt_req, tgt_offset, tgt_rnw);
    end
    n_checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_wait_flags: got ready=%b valid=%b want 0 0", req_ready, rsp_valid);
    end
    tgt_ack   = 2'b01;
    tgt_rdata = {32'h1111_2222, 32'hDEAD_BEEF};
    step();
    tgt_ack = 2'b00;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL rd_rsp: got valid=%b rdata=%h err=%b want 1 deadbeef 0",
                         rsp_valid, rsp_rdata, rsp_err);
    end
    n_checks++; if (tgt_req !== 2'b00) begin
      n_fail++; $display("FAIL rd_req_drop: got %b want 00", tgt_req); end
    step();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_done: got valid=%b ready=%b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_write_hit();
    drive_req(1'b0, 32'h8000_100C, 32'h0000_1234, 4'b0011);
    n_checks++; if (tgt_req !== 2'b10 || tgt_offset !== 32'd3 || tgt_rnw !== 1'b0) begin
      n_fail++; $display("FAIL wr_tgt: got req=%b off=%h rnw=%b want 10 3 0",
                         tgt_req, tgt_offset, tgt_rnw);
    end
    n_checks++; if (tgt_wdata !== 32'h0000_1234 || tgt_be !== 4'b0011) begin
      n_fail++; $display("FAIL wr_pass: got wd=%h be=%b want 00001234 0011", tgt_wdata, tgt_be);
    end
    // Ack from the other region must be ignored.
    tgt_ack   = 2'b01;
    tgt_rdata = {32'h5555_5555, 32'hAAAA_AAAA};
    step();
    tgt_ack = 2'b00;
    n_checks++; if (tgt_req !== 2'b10 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL wr_stray_ack: got req=%b valid=%b want 10 0", tgt_req, rsp_valid);
    end
    tgt_ack = 2'b10;
    step();
    tgt_ack = 2'b00;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      n_fail++; $display("FAIL wr_rsp: got valid=%b rdata=%h err=%b want 1 0 0",
                         rsp_valid, rsp_rdata, rsp_err);
    end
    step();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3] = '{32'h8000_0004, 32'h8000_1002, 32'h7FFF_FFFC};
    logic [1:0]  codes [3] = '{2'd1, 2'd2, 2'd1};
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b1, addrs[i], 32'h0, 4'hF);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
        n_fail++; $display("FAIL err_rsp[%0d]: got valid=%b err=%b rdata=%h want 1 1 0",
                           i, rsp_valid, rsp_err, rsp_rdata);
      end
      n_checks++; if (tgt_req !== 2'b00 || rsp_err_code !== codes[i]) begin
        n_fail++; $display("FAIL err_code[%0d]: got req=%b code=%0d want 00 %0d",
                           i, tgt_req, rsp_err_code, codes[i]);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    int bad;
    drive_req(1'b1, 32'h8000_1000, 32'h0, 4'hF);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (tgt_req !== 2'b10 || rsp_valid !== 1'b0) bad++;
      step();
    end
    n_checks++; if (bad != 0) begin
      n_fail++; $display("FAIL to_hold: got %0d bad wait cycles want 0", bad); end
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL to_rsp: got valid=%b err=%b rdata=%h want 1 1 0",
                         rsp_valid, rsp_err, rsp_rdata);
    end
    n_checks++; if (tgt_req !== 2'b00 || rsp_err_code !== 2'd3) begin
      n_fail++; $display("FAIL to_code: got req=%b code=%0d want 00 3", tgt_req, rsp_err_code);
    end
    step();
    // Ack in the final allowed cycle wins over the timeout.
    drive_req(1'b1, 32'h8000_1004, 32'h0, 4'hF);
    repeat (15) step();
    tgt_ack   = 2'b10;
    tgt_rdata = {32'hCAFE_F00D, 32'h0};
    step();
    tgt_ack = 2'b00;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFE_F00D) begin
      n_fail++; $display("FAIL to_last_ack: got valid=%b err=%b rdata=%h want 1 0 cafef00d",
                         rsp_valid, rsp_err, rsp_rdata);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int bad;
    rsp_ready = 1'b0;
    drive_req(1'b1, 32'h8000_0004, 32'h0, 4'hF);
    // Next request presented while the response is stalled.
    req_rnw   = 1'b1;
    req_addr  = 32'h8000_0000;
    req_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 ||
          req_ready !== 1'b0 || tgt_req !== 2'b00) bad++;
      step();
    end
    n_checks++; if (bad != 0) begin
      n_fail++; $display("FAIL b2b_stall: got %0d unstable cycles want 0", bad); end
    rsp_ready = 1'b1;
    step();
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || tgt_req !== 2'b00) begin
      n_fail++; $display("FAIL b2b_handshake: got valid=%b ready=%b req=%b want 0 1 00",
                         rsp_valid, req_ready, tgt_req);
    end
    step();
    req_valid = 1'b0;
    n_checks++; if (tgt_req !== 2'b01 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_accept: got req=%b ready=%b want 01 0", tgt_req, req_ready);
    end
    tgt_ack   = 2'b01;
    tgt_rdata = {32'h0, 32'h0BAD_F00D};
    step();
    tgt_ack = 2'b00;
    n_checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BAD_F00D) begin
      n_fail++; $display("FAIL b2b_rsp: got valid=%b rdata=%h want 1 0badf00d", rsp_valid, rsp_rdata);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    drive_req(1'b1, 32'h8000_0000, 32'h0, 4'hF);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if (tgt_req !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait: got req=%b valid=%b ready=%b want 00 0 1",
                         tgt_req, rsp_valid, req_ready);
    end
    tgt_ack   = 2'b01;
    tgt_rdata = {32'h0, 32'h1234_5678};
    step();
    tgt_ack = 2'b00;
    n_checks++; if (rsp_valid !== 1'b0 || tgt_req !== 2'b00 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_late_ack: got valid=%b req=%b ready=%b want 0 00 1",
                         rsp_valid, tgt_req, req_ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rnw   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_be    = '0;
    rsp_ready = 1'b1;
    tgt_ack   = '0;
    tgt_rdata = '0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_errors();
    test_timeout();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
